wb_commit_cp0: RTL

Write-back and exception-commit stage for the five-stage MIPS pipeline. Consumes the MEM/WB pipeline register outputs and produces the register-file write port. Owns the CP0 Status, Cause and EPC registers. Turns a faulting or ERET instruction reaching write-back into a pipeline flush plus PC redirect.

---
 rtl/wb_commit_cp0.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/wb_commit_cp0.sv
// +-----------------------------------------------------------------------------+
// | Module : wb_commit_cp0                                                      |
// | Desc   : MIPS write-back stage with CP0 Status/Cause/EPC and commit flush.  |
// | Rev    : 1.0  initial release                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module wb_commit_cp0 #(
  parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemtoReg_in,
  input  logic        RegWrite_in,
  input  logic [2:0]  MemRead_in,
  input  logic [31:0] Mem_Data_in,
  input  logic [31:0] ALU_Data_in,
  input  logic [4:0]  Reg_Write_in,
  input  logic        MEM_WB_IS_NOP,
  input  logic        overflow_in,
  input  logic [31:0] OPC_in,
  input  logic [4:0]  EXCCODE_in,
  input  logic [31:0] ins_in,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] status_out,
  output logic [31:0] cause_out,
  output logic [31:0] epc_out
);

  localparam logic [31:0] c_eret_word  = 32'h4200_0018;
  localparam logic [10:0] c_mtc0_op    = 11'b010000_00100;
  localparam logic [10:0] c_mfc0_op    = 11'b010000_00000;
  localparam logic [4:0]  c_code_ov    = 5'd12;
  localparam logic [3:0]  c_drain_init = 4'(DRAIN_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t      r_state, w_state_next;
  logic [3:0]  r_drain_cnt, w_drain_cnt_next;
  logic [31:0] r_status, r_cause, r_epc, r_redirect_pc;
  logic        r_redirect_valid, r_flush;

  logic        w_live, w_exc, w_eret, w_mtc0, w_mfc0, w_commit;
  logic [4:0]  w_code, w_rd;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load, w_cp0_rdata;

  assign w_live   = !MEM_WB_IS_NOP && (r_state == ST_RUN);
  assign w_exc    = w_live && ((EXCCODE_in != 5'd0) || overflow_in);
  assign w_code   = (EXCCODE_in != 5'd0) ? EXCCODE_in : c_code_ov;
  assign w_eret   = w_live && !w_exc && (ins_in == c_eret_word);
  assign w_mtc0   = w_live && !w_exc && !w_eret && (ins_in[31:21] == c_mtc0_op);
  assign w_mfc0   = w_live && !w_exc && !w_eret && (ins_in[31:21] == c_mfc0_op);
  assign w_commit = w_exc || w_eret;
  assign w_rd     = ins_in[15:11];

  // Load extraction: byte lane from addr[1:0], halfword from addr[1].
  always_comb begin
    w_byte = 8'h00;
    case (ALU_Data_in[1:0])
      2'd0:    w_byte = Mem_Data_in[7:0];
      2'd1:    w_byte = Mem_Data_in[15:8];
      2'd2:    w_byte = Mem_Data_in[23:16];
      default: w_byte = Mem_Data_in[31:24];
    endcase
    w_half = ALU_Data_in[1] ? Mem_Data_in[31:16] : Mem_Data_in[15:0];
    w_load = Mem_Data_in;
    case (MemRead_in)
      3'd2:    w_load = {{24{w_byte[7]}}, w_byte};
      3'd3:    w_load = {24'h000000, w_byte};
      3'd4:    w_load = {{16{w_half[15]}}, w_half};
      3'd5:    w_load = {16'h0000, w_half};
      default: w_load = Mem_Data_in;
    endcase
  end

  always_comb begin
    w_cp0_rdata = 32'h0000_0000;
    case (w_rd)
      5'd12:   w_cp0_rdata = r_status;
      5'd13:   w_cp0_rdata = r_cause;
      5'd14:   w_cp0_rdata = r_epc;
      default: w_cp0_rdata = 32'h0000_0000;
    endcase
  end

  assign rf_we    = rst_n && w_live && !w_exc && !w_eret && !w_mtc0 && RegWrite_in;
  assign rf_waddr = Reg_Write_in;
  assign rf_wdata = w_mfc0 ? w_cp0_rdata : (MemtoReg_in ? w_load : ALU_Data_in);

  always_comb begin
    w_state_next     = r_state;
    w_drain_cnt_next = r_drain_cnt;
    case (r_state)
      ST_RUN: begin
        if (w_commit) begin
          w_state_next     = ST_DRAIN;
          w_drain_cnt_next = c_drain_init;
        end
      end
      ST_DRAIN: begin
        if (r_drain_cnt == 4'd0) w_state_next = ST_RUN;
        else                     w_drain_cnt_next = r_drain_cnt - 4'd1;
      end
      default: w_state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= ST_RUN;
      r_drain_cnt      <= 4'd0;
      r_flush          <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= 32'h0000_0000;
    end else begin
      r_state          <= w_state_next;
      r_drain_cnt      <= w_drain_cnt_next;
      r_flush          <= (w_state_next == ST_DRAIN);
      r_redirect_valid <= w_commit;
      if (w_commit) r_redirect_pc <= w_exc ? EXC_VECTOR : r_epc;
    end
  end

  // MTC0 source operand arrives on the ALU result path (rt forwarded through EX).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_status <= 32'h0000_0000;
      r_cause  <= 32'h0000_0000;
      r_epc    <= 32'h0000_0000;
    end else if (w_exc) begin
      r_cause[6:2] <= w_code;
      if (!r_status[1]) r_epc <= OPC_in;
      r_status[1]  <= 1'b1;
    end else if (w_eret) begin
      r_status[1] <= 1'b0;
    end else if (w_mtc0) begin
      case (w_rd)
        5'd12:   r_status     <= ALU_Data_in;
        5'd13:   r_cause[9:8] <= ALU_Data_in[9:8];
        5'd14:   r_epc        <= ALU_Data_in;
        default: ;
      endcase
    end
  end

  assign flush          = r_flush;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign status_out     = r_status;
  assign cause_out      = r_cause;
  assign epc_out        = r_epc;

endmodule

`default_nettype wire
